btn_conditioner: RTL
====================

Name: btn_conditioner

Overview:
- Front-end for the five direction buttons feeding the control core's l/r/u/d/c_btn and *_btn_dn inputs.
- Per button: 2-FF synchronizer, debounce filter, press/release edge pulses and hold-to-repeat pulses.
- Runs on the 600p pixel clock (40 MHz) in the core's clock domain, so no further CDC is needed downstream.
- One instance covers all N buttons; lanes are independent and identical.

Parameters:
- N, 5, number of button lanes (bit 0=L, 1=R, 2=U, 3=D, 4=C).
- DEBOUNCE_CYCLES, 400000, consecutive stable cycles required to accept a level change (10 ms at 40 MHz); must be >= 1.
- REPEAT_DELAY, 16000000, cycles from accepted press to first repeat pulse (400 ms); must be >= 1.
- REPEAT_PERIOD, 4000000, cycles between subsequent repeat pulses (100 ms); must be >= 1.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous, active-high reset.
- raw  in  N  asynchronous button pins, active-high.
- level  out  N  debounced button state (drives core *_btn).
- dn  out  N  1-cycle pulse on accepted press (drives core *_btn_dn).
- up  out  N  1-cycle pulse on accepted release.
- rpt  out  N  1-cycle auto-repeat pulse while held.
- pulse  out  N  dn | rpt, for single-step consumers.
- any_dn  out  1  OR-reduction of dn.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - Sync flops, debounce counters, repeat counters: 0.
  - level, dn, up, rpt, pulse, any_dn: 0.
  - Repeat FSM: IDLE.
  - Applies mid-debounce or mid-repeat with no residual pulse on the following cycle.
- Synchronizer: s1 <= raw; s2 <= s1. No logic between s1 and s2.
- Debounce, per lane (counter width $clog2(DEBOUNCE_CYCLES+1)):
  - s2 == level: cnt <= 0. Any bounce back restarts the filter.
  - s2 != level and cnt == DEBOUNCE_CYCLES-1: level <= s2, cnt <= 0.
  - Otherwise cnt <= cnt+1.
  - Latency: level changes on the (DEBOUNCE_CYCLES+2)-th rising edge counting the first edge that samples the new raw value.
- Edge pulses, all registered:
  - dn is high exactly in the first cycle level reads 1.
  - up is high exactly in the first cycle level reads 0 after having been 1.
  - Each is a single cycle wide.
- Repeat FSM, per lane (states IDLE, DELAY, REPEAT; counter width sized for max(REPEAT_DELAY, REPEAT_PERIOD)):
  - IDLE: on the edge where level rises -> DELAY, rcnt <= 0.
  - DELAY: if rcnt == REPEAT_DELAY-1 then rpt pulse, rcnt <= 0, -> REPEAT; else rcnt+1. First rpt occurs REPEAT_DELAY cycles after the dn cycle.
  - REPEAT: if rcnt == REPEAT_PERIOD-1 then rpt pulse, rcnt <= 0; else rcnt+1.
  - Any state: on the edge where level falls -> IDLE, rcnt <= 0, rpt 0.
  - Release takes priority over a simultaneous repeat expiry: no rpt in the up cycle.
  - dn and rpt never coincide, since REPEAT_DELAY >= 1.
- pulse = dn | rpt and any_dn = |dn, both combinational from registered outputs, so there is no extra latency.
- Lanes are fully independent: simultaneous presses on several lanes each produce their own dn in the same cycle.
- No ordering or priority between lanes; the core resolves conflicts.

Test Plan (bench params DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3):
- Reset, then raw[0]=1 from edge 0 and held -> level[0]=1 and dn[0]=1 after edge 5 only; dn[0]=0 after edge 6; other lanes stay 0.
- raw[2] toggles 1,1,0,1,1,0 each cycle, then held 1 -> level[2] rises only 6 edges after the final steady-1 sample; exactly one dn[2].
- Hold raw[1] for 30 cycles past dn -> rpt[1] at dn+10, +13, +16, +19, ... (period 3); pulse[1] mirrors dn|rpt.
- Release raw[1] in the cycle a repeat would expire -> up[1] asserted 6 edges after release sampling; no further rpt; FSM back in IDLE. The next press needs the full 10-cycle delay again.
- Assert rst mid-REPEAT with raw held -> all outputs 0 after the reset edge. After rst drops, a fresh dn follows 6 edges later (re-debounce from level=0).
- Press raw[3] and raw[4] on the same edge -> dn[3] and dn[4] in the same cycle; any_dn=1 for exactly 1 cycle.

Source files
------------

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - per-lane button synchronizer, debounce, edge and auto-repeat pulses
module btn_conditioner #(
    parameter int N               = 5,
    parameter int DEBOUNCE_CYCLES = 400000,
    parameter int REPEAT_DELAY    = 16000000,
    parameter int REPEAT_PERIOD   = 4000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] raw,
    output logic [N-1:0] level,
    output logic [N-1:0] dn,
    output logic [N-1:0] up,
    output logic [N-1:0] rpt,
    output logic [N-1:0] pulse,
    output logic         any_dn
);

    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DB_ONE      = DW'(1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
    localparam logic [RW-1:0] R_ONE       = RW'(1);

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_REPEAT
    } rpt_state_e;

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic          s1_q, s1_d, s2_q, s2_d;
        logic          level_q, level_d;
        logic          dn_q, dn_d, up_q, up_d, rpt_q, rpt_d;
        logic [DW-1:0] db_cnt_q, db_cnt_d;
        logic [RW-1:0] rcnt_q, rcnt_d;
        rpt_state_e    state_q, state_d;

        always_comb begin
            s1_d     = raw[i];
            s2_d     = s1_q;
            level_d  = level_q;
            db_cnt_d = db_cnt_q;

            // Any sample agreeing with the current level restarts the filter.
            if (s2_q == level_q) begin
                db_cnt_d = '0;
            end else if (db_cnt_q == DB_LAST) begin
                level_d  = s2_q;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + DB_ONE;
            end

            dn_d = level_d & ~level_q;
            up_d = ~level_d & level_q;

            state_d = state_q;
            rcnt_d  = rcnt_q;
            rpt_d   = 1'b0;

            // Release wins over a repeat expiring on the same edge.
            if (up_d) begin
                state_d = RPT_IDLE;
                rcnt_d  = '0;
            end else begin
                case (state_q)
                    RPT_IDLE: begin
                        if (dn_d) begin
                            state_d = RPT_DELAY;
                            rcnt_d  = '0;
                        end
                    end
                    RPT_DELAY: begin
                        if (rcnt_q == DELAY_LAST) begin
                            rpt_d   = 1'b1;
                            rcnt_d  = '0;
                            state_d = RPT_REPEAT;
                        end else begin
                            rcnt_d = rcnt_q + R_ONE;
                        end
                    end
                    RPT_REPEAT: begin
                        if (rcnt_q == PERIOD_LAST) begin
                            rpt_d  = 1'b1;
                            rcnt_d = '0;
                        end else begin
                            rcnt_d = rcnt_q + R_ONE;
                        end
                    end
                    default: begin
                        state_d = RPT_IDLE;
                        rcnt_d  = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                s1_q     <= 1'b0;
                s2_q     <= 1'b0;
                level_q  <= 1'b0;
                db_cnt_q <= '0;
                dn_q     <= 1'b0;
                up_q     <= 1'b0;
                rpt_q    <= 1'b0;
                rcnt_q   <= '0;
                state_q  <= RPT_IDLE;
            end else begin
                s1_q     <= s1_d;
                s2_q     <= s2_d;
                level_q  <= level_d;
                db_cnt_q <= db_cnt_d;
                dn_q     <= dn_d;
                up_q     <= up_d;
                rpt_q    <= rpt_d;
                rcnt_q   <= rcnt_d;
                state_q  <= state_d;
            end
        end

        assign level[i] = level_q;
        assign dn[i]    = dn_q;
        assign up[i]    = up_q;
        assign rpt[i]   = rpt_q;
    end

    assign pulse  = dn | rpt;
    assign any_dn = |dn;

endmodule
